aes_block_loader: RTL and testbench

Upstream feeder for the AES encryption core. Accepts plaintext as a stream of 32-bit words with a valid/ready handshake and packs four words into a 128-bit block. It launches the core with a one-cycle `aes_start` pulse, then holds the launched block stable until the core signals completion. It is double-buffered, so the next block can be filled while the core is encrypting the current one.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_edge_detect.sv | 24 ++
 rtl/aes_block_loader.sv | 119 +++++++++++
 tb/tb_aes_block_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, loader FSM states and word placement helper.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } loader_state_t;

  // Top bit of word k inside a block; word 0 occupies the most significant slice.
  function automatic int unsigned word_msb(input int unsigned k, input int unsigned word_w);
    return AES_BLOCK_W - 1 - k * word_w;
  endfunction

endpackage

// File: rtl/aes_edge_detect.sv
// Registered rising-edge detector with synchronous active-low reset.
module aes_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q, d_d;

  always_comb begin
    d_d  = d;
    rise = d && !d_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/aes_block_loader.sv
// Packs streamed plaintext words into 128-bit blocks and launches the AES core,
// filling the next block while the current one is being encrypted.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WORD_W-1:0]      in_word,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   abort,
  output logic [AES_BLOCK_W-1:0] originaltext,
  output logic                   aes_start,
  input  logic                   aes_done,
  output logic                   busy,
  output logic [CNT_W-1:0]       blk_count
);

  localparam int unsigned WORDS  = AES_BLOCK_W / WORD_W;
  localparam int unsigned WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  loader_state_t          state_q, state_d;
  logic [AES_BLOCK_W-1:0] fill_buf_q, fill_buf_d;
  logic [AES_BLOCK_W-1:0] text_q, text_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic                   full_q, full_d;
  logic                   start_q, start_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_rise;
  logic                   accept;
  logic                   launch;

  aes_edge_detect u_done_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (aes_done),
    .rise (done_rise)
  );

  always_comb begin
    in_ready     = !full_q && rst_n;
    accept       = in_valid && in_ready && !abort;
    launch       = (state_q == IDLE) && full_q && !abort;
    originaltext = text_q;
    aes_start    = start_q;
    busy         = (state_q == BUSY);
    blk_count    = cnt_q;
  end

  always_comb begin
    fill_buf_d = fill_buf_q;
    wcnt_d     = wcnt_q;
    full_d     = full_q;
    state_d    = state_q;
    text_d     = text_q;
    start_d    = 1'b0;
    cnt_d      = cnt_q;

    // A word arriving together with abort is dropped.
    if (abort) begin
      wcnt_d = '0;
      full_d = 1'b0;
    end else if (accept) begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        if (wcnt_q == WCNT_W'(k)) begin
          fill_buf_d[word_msb(k, WORD_W) -: WORD_W] = in_word;
        end
      end
      if (wcnt_q == WCNT_W'(WORDS - 1)) begin
        wcnt_d = '0;
        full_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (launch) begin
          text_d  = fill_buf_q;
          full_d  = 1'b0;
          start_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fill_buf_q <= '0;
      text_q     <= '0;
      wcnt_q     <= '0;
      full_q     <= 1'b0;
      start_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_buf_q <= fill_buf_d;
      text_q     <= text_d;
      wcnt_q     <= wcnt_d;
      full_q     <= full_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed scoreboard bench for aes_block_loader (counter narrowed to 4 bits to reach the wrap).
module tb_aes_block_loader;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WORD_W-1:0] in_word = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              abort = 1'b0;
  logic [127:0]      originaltext;
  logic              aes_start;
  logic              aes_done = 1'b0;
  logic              busy;
  logic [CNT_W-1:0]  blk_count;

  aes_block_loader #(
    .WORD_W(WORD_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_word     (in_word),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .abort       (abort),
    .originaltext(originaltext),
    .aes_start   (aes_start),
    .aes_done    (aes_done),
    .busy        (busy),
    .blk_count   (blk_count)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               starts = 0;
  logic [CNT_W-1:0] model_cnt = '0;
  logic [127:0]     cur_text = '0;
  logic             prev_start = 1'b0;
  logic [127:0]     exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) model_cnt = '0;
  end

  // Scoreboard: every launch pops the next expected block.
  always @(negedge clk) begin
    if (aes_start) begin
      starts++;
      model_cnt = model_cnt + 1'b1;
      check("start_single_cycle", prev_start, 1'b0);
      check("launch_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        cur_text = exp_q.pop_front();
        check("originaltext", originaltext, cur_text);
      end
      check("blk_count", blk_count, model_cnt);
    end else if (busy) begin
      check("text_stable_busy", originaltext, cur_text);
    end
    prev_start = aes_start;
  end

  task automatic send_word(input logic [31:0] w, output int hs);
    bit done = 1'b0;
    hs = -1;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = w;
      if (in_ready) begin
        done = 1'b1;
        hs   = cyc;
      end
    end
    check("handshake_in_time", done, 1'b1);
  endtask

  // Returns on the negedge after the last handshake with in_valid dropped.
  task automatic send_block(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3, output int last_hs);
    logic [31:0] ws[4];
    ws = '{w0, w1, w2, w3};
    last_hs = -1;
    for (int k = 0; k < 4; k++) send_word(ws[k], last_hs);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output int at);
    bit found = 1'b0;
    at = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (aes_start) begin
        found = 1'b1;
        at    = cyc;
      end
    end
    check("start_seen", found, 1'b1);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    aes_done = 1'b1;
    @(negedge clk);
    aes_done = 1'b0;
  endtask

  initial begin
    int n, s, m, s0, hs;
    logic [CNT_W-1:0] c0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_start", aes_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", blk_count, '0);
    check("rst_text", originaltext, '0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", in_ready, 1'b1);

    // Basic fill and launch
    exp_q.push_back(128'h00112233445566778899aabbccddeeff);
    send_block(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, n);
    check("fill_ready_low", in_ready, 1'b0);
    check("no_early_start", aes_start, 1'b0);
    wait_start(s);
    check("launch_latency", s - n, 2);
    check("busy_on_launch", busy, 1'b1);
    check("ready_on_launch", in_ready, 1'b1);
    check("count_first", blk_count, 4'd1);

    // Pipelined second block while the first is in flight
    exp_q.push_back(128'h00000000000000010000000200000003);
    send_block(32'h0, 32'h1, 32'h2, 32'h3, n);
    check("pipe_ready_low", in_ready, 1'b0);
    s0 = starts;
    repeat (5) @(negedge clk);
    check("no_start_while_busy", starts, s0);
    check("still_busy", busy, 1'b1);
    check("pipe_ready_held", in_ready, 1'b0);
    aes_done = 1'b1;
    m = cyc;
    wait_start(s);
    check("relaunch_latency", s - m, 2);

    // aes_done held high must not complete the freshly launched block
    repeat (10) @(negedge clk);
    check("held_done_busy", busy, 1'b1);
    check("held_done_one_start", starts, s0 + 1);
    aes_done = 1'b0;
    @(negedge clk);
    aes_done = 1'b1;
    @(negedge clk);
    check("done_to_idle", busy, 1'b0);
    aes_done = 1'b0;
    @(negedge clk);
    aes_done = 1'b1;
    c0 = blk_count;
    s0 = starts;
    repeat (4) @(negedge clk);
    check("stray_no_start", starts, s0);
    check("stray_no_count", blk_count, c0);
    check("stray_idle", busy, 1'b0);
    aes_done = 1'b0;

    // Abort drops the partial block and a word presented alongside it
    send_word(32'h11111111, hs);
    send_word(32'h22222222, hs);
    @(negedge clk);
    in_word = 32'hdeadbeef;
    abort   = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    exp_q.push_back(128'haaaaaaaabbbbbbbbccccccccdddddddd);
    send_block(32'haaaaaaaa, 32'hbbbbbbbb, 32'hcccccccc, 32'hdddddddd, n);
    wait_start(s);
    check("abort_latency", s - n, 2);
    pulse_done();

    // Reset while busy with a full buffer waiting
    exp_q.push_back(128'h0123456789abcdeffedcba9876543210);
    send_block(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, n);
    wait_start(s);
    send_block(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, n);
    check("midflight_full", in_ready, 1'b0);
    check("midflight_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_count", blk_count, '0);
    check("mid_rst_text", originaltext, '0);
    check("mid_rst_start", aes_start, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    s0 = starts;
    repeat (6) @(negedge clk);
    check("post_rst_no_start", starts, s0);
    check("post_rst_idle", busy, 1'b0);
    exp_q.push_back(128'hcafef00d0badc0de1234567800c0ffee);
    send_block(32'hcafef00d, 32'h0badc0de, 32'h12345678, 32'h00c0ffee, n);
    wait_start(s);
    check("post_rst_count", blk_count, 4'd1);
    pulse_done();

    // Counter wrap: 17 launches on a 4-bit counter
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s0 = starts;
    for (int i = 0; i < 17; i++) begin
      logic [31:0] b;
      b = 32'h1000_0000 + 32'(i * 4);
      exp_q.push_back({b, b + 32'd1, b + 32'd2, b + 32'd3});
      send_block(b, b + 32'd1, b + 32'd2, b + 32'd3, n);
      wait_start(s);
      pulse_done();
    end
    check("wrap_starts", starts - s0, 17);
    check("wrap_count", blk_count, 4'd1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
